// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter, data over fetch with a streak cap (ARB_STATS_EN adds grant counters).
// Grant is combinational, read data returns registered 2 edges after grant; requesters stall by holding req until gnt.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_r_not_w_o,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       if_gnt_cnt_o,
    output logic [15:0]       d_gnt_cnt_o
`endif
);

    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_IF   = 2'd1;
    localparam logic [1:0] ST_D    = 2'd2;
    localparam logic [7:0] STREAK_MAX = 8'(MAX_D_STREAK);

    logic [1:0]        pend_q;
    logic              pend_kill_q;
    logic [7:0]        streak_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              fetch_wins;

    always_comb begin
        fetch_wins    = if_req_i && (!d_req_i || (streak_q == STREAK_MAX));
        if_gnt_o      = !reset_i && fetch_wins;
        d_gnt_o       = !reset_i && d_req_i && !fetch_wins;
        mem_r_not_w_o = 1'b1;
        mem_addr_o    = addr_q;
        mem_wdata_o   = wdata_q;
        if (if_gnt_o) begin
            mem_addr_o = if_addr_i;
        end else if (d_gnt_o) begin
            mem_addr_o    = d_addr_i;
            mem_wdata_o   = d_wdata_i;
            mem_r_not_w_o = ~d_we_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pend_q      <= ST_NONE;
            pend_kill_q <= 1'b0;
            streak_q    <= 8'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rvalid_o <= 1'b0;
            if_rdata_o  <= '0;
            d_rvalid_o  <= 1'b0;
            d_rdata_o   <= '0;
        end else begin
            // A flush in the grant cycle is remembered so that return is dropped too.
            if (if_gnt_o) begin
                pend_q      <= ST_IF;
                pend_kill_q <= flush_i;
            end else if (d_gnt_o && !d_we_i) begin
                pend_q      <= ST_D;
                pend_kill_q <= 1'b0;
            end else begin
                pend_q      <= ST_NONE;
                pend_kill_q <= 1'b0;
            end

            addr_q  <= mem_addr_o;
            wdata_q <= mem_wdata_o;

            if (if_gnt_o || !if_req_i) begin
                streak_q <= 8'd0;
            end else if (d_gnt_o && (streak_q != STREAK_MAX)) begin
                streak_q <= streak_q + 8'd1;
            end

            if_rvalid_o <= (pend_q == ST_IF) && !pend_kill_q && !flush_i;
            if ((pend_q == ST_IF) && !pend_kill_q && !flush_i) begin
                if_rdata_o <= mem_rdata_i;
            end

            d_rvalid_o <= (pend_q == ST_D);
            if (pend_q == ST_D) begin
                d_rdata_o <= mem_rdata_i;
            end
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            if_gnt_cnt_o <= 16'd0;
            d_gnt_cnt_o  <= 16'd0;
        end else begin
            if (if_gnt_o && (if_gnt_cnt_o != 16'hFFFF)) begin
                if_gnt_cnt_o <= if_gnt_cnt_o + 16'd1;
            end
            if (d_gnt_o && (d_gnt_cnt_o != 16'hFFFF)) begin
                d_gnt_cnt_o <= d_gnt_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model plus per-owner return scoreboards checked by a negedge monitor.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        flush_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_r_not_w_o;
    logic [31:0] mem_rdata_i;
`ifdef ARB_STATS_EN
    logic [15:0] if_gnt_cnt_o;
    logic [15:0] d_gnt_cnt_o;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_if_cnt = 0;
    int exp_d_cnt  = 0;

    logic [31:0] exp_if_dat[$];
    int          exp_if_due[$];
    logic [31:0] exp_d_dat[$];
    int          exp_d_due[$];
    logic [31:0] mem_store [logic [31:0]];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .flush_i(flush_i),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_r_not_w_o(mem_r_not_w_o),
        .mem_rdata_i(mem_rdata_i)
`ifdef ARB_STATS_EN
        , .if_gnt_cnt_o(if_gnt_cnt_o), .d_gnt_cnt_o(d_gnt_cnt_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_read(logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory: read data appears the cycle after a read is issued.
    always @(posedge clk) begin
        if ((if_gnt_o || d_gnt_o) && !reset_i) begin
            if (mem_r_not_w_o) mem_rdata_i <= mem_read(mem_addr_o);
            else mem_store[mem_addr_o] = mem_wdata_o;
        end else begin
            mem_rdata_i <= 32'hBAD0BAD0;
        end
    end

    always @(negedge clk) begin
        if (if_rvalid_o) begin
            total++;
            if (exp_if_dat.size() == 0) begin
                bad++;
                $display("FAIL if_return: unexpected if_rvalid_o at cycle %0d data %h", cyc, if_rdata_o);
            end else begin
                logic [31:0] d;
                int due;
                d = exp_if_dat.pop_front();
                due = exp_if_due.pop_front();
                if (if_rdata_o !== d || cyc != due) begin
                    bad++;
                    $display("FAIL if_return: got %h at cycle %0d, want %h at cycle %0d", if_rdata_o, cyc, d, due);
                end
            end
        end
        if (d_rvalid_o) begin
            total++;
            if (exp_d_dat.size() == 0) begin
                bad++;
                $display("FAIL d_return: unexpected d_rvalid_o at cycle %0d data %h", cyc, d_rdata_o);
            end else begin
                logic [31:0] d;
                int due;
                d = exp_d_dat.pop_front();
                due = exp_d_due.pop_front();
                if (d_rdata_o !== d || cyc != due) begin
                    bad++;
                    $display("FAIL d_return: got %h at cycle %0d, want %h at cycle %0d", d_rdata_o, cyc, d, due);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_if(logic [31:0] d);
        exp_if_dat.push_back(d);
        exp_if_due.push_back(cyc + 2);
    endtask

    task automatic push_d(logic [31:0] d);
        exp_d_dat.push_back(d);
        exp_d_due.push_back(cyc + 2);
    endtask

    task automatic wait_drain(string name);
        for (int i = 0; i < 10 && (exp_if_dat.size() + exp_d_dat.size()) > 0; i++) tick();
        total++;
        if ((exp_if_dat.size() + exp_d_dat.size()) != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d returns outstanding, want 0", name, exp_if_dat.size() + exp_d_dat.size());
            exp_if_dat.delete(); exp_if_due.delete();
            exp_d_dat.delete();  exp_d_due.delete();
        end
    endtask

    task automatic test_reset;
        reset_i = 1'b1; if_req_i = 1'b1; d_req_i = 1'b1; d_we_i = 1'b0; flush_i = 1'b0;
        if_addr_i = 32'h44; d_addr_i = 32'h88; d_wdata_i = 32'h1234_5678;
        tick(); tick(); #1;
        total++;
        if ({if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o} !== 4'b0000 || mem_r_not_w_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_ctrl: gnt/rvalid=%b r_not_w=%b, want 0000 and 1",
                     {if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o}, mem_r_not_w_o);
        end
        total++;
        if (if_rdata_o !== 32'h0 || d_rdata_o !== 32'h0 || mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: if_rdata=%h d_rdata=%h addr=%h wdata=%h, want all 0",
                     if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o);
        end
`ifdef ARB_STATS_EN
        total++;
        if (if_gnt_cnt_o !== 16'd0 || d_gnt_cnt_o !== 16'd0) begin
            bad++;
            $display("FAIL reset_stats: %h %h, want 0 0", if_gnt_cnt_o, d_gnt_cnt_o);
        end
`endif
        if_req_i = 1'b0; d_req_i = 1'b0;
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_fetch;
        if_req_i = 1'b1; if_addr_i = 32'h10;
        #1;
        total++;
        if (if_gnt_o !== 1'b1 || d_gnt_o !== 1'b0 || mem_addr_o !== 32'h10 || mem_r_not_w_o !== 1'b1) begin
            bad++;
            $display("FAIL fetch_issue: if_gnt=%b d_gnt=%b addr=%h r_not_w=%b, want 1 0 00000010 1",
                     if_gnt_o, d_gnt_o, mem_addr_o, mem_r_not_w_o);
        end
        push_if(32'hE3A01005);
        exp_if_cnt++;
        tick();
        if_req_i = 1'b0;
        wait_drain("fetch");
    endtask

    task automatic test_contention;
        logic [5:0] if_wins;
        if_wins = 6'b010000;
        if_req_i = 1'b1; if_addr_i = 32'h40;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h100;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (if_gnt_o !== if_wins[i] || d_gnt_o !== !if_wins[i] ||
                mem_addr_o !== (if_wins[i] ? 32'h40 : 32'h100)) begin
                bad++;
                $display("FAIL contention_%0d: if_gnt=%b d_gnt=%b addr=%h, want if_gnt=%b", i,
                         if_gnt_o, d_gnt_o, mem_addr_o, if_wins[i]);
            end
            if (if_wins[i]) begin
                push_if(32'h0040FFBF); exp_if_cnt++;
            end else begin
                push_d(32'h0100FEFF); exp_d_cnt++;
            end
            tick();
        end
        if_req_i = 1'b0; d_req_i = 1'b0;
        wait_drain("contention");
    endtask

    task automatic test_store;
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h20; d_wdata_i = 32'hDEADBEEF;
        #1;
        total++;
        if (d_gnt_o !== 1'b1 || mem_r_not_w_o !== 1'b0 || mem_addr_o !== 32'h20 || mem_wdata_o !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL store_issue: d_gnt=%b r_not_w=%b addr=%h wdata=%h, want 1 0 00000020 deadbeef",
                     d_gnt_o, mem_r_not_w_o, mem_addr_o, mem_wdata_o);
        end
        exp_d_cnt++;
        tick();
        d_we_i = 1'b0; d_wdata_i = 32'h0;
        #1;
        total++;
        if (d_gnt_o !== 1'b1 || mem_r_not_w_o !== 1'b1) begin
            bad++;
            $display("FAIL store_reload_issue: d_gnt=%b r_not_w=%b, want 1 1", d_gnt_o, mem_r_not_w_o);
        end
        push_d(32'hDEADBEEF);
        exp_d_cnt++;
        tick();
        d_req_i = 1'b0;
        wait_drain("store");
    endtask

    task automatic test_back_to_back;
        if_req_i = 1'b1; if_addr_i = 32'h10;
        #1;
        total++;
        if (if_gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_fetch_gnt: got %b want 1", if_gnt_o);
        end
        push_if(32'hE3A01005); exp_if_cnt++;
        tick();
        if_req_i = 1'b0; d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h100;
        #1;
        total++;
        if (d_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_load_gnt: d_gnt=%b if_gnt=%b want 1 0", d_gnt_o, if_gnt_o);
        end
        push_d(32'h0100FEFF); exp_d_cnt++;
        tick();
        d_req_i = 1'b0; d_addr_i = 32'h7777;
        #1;
        total++;
        if (if_gnt_o !== 1'b0 || d_gnt_o !== 1'b0 || mem_r_not_w_o !== 1'b1 || mem_addr_o !== 32'h100) begin
            bad++;
            $display("FAIL idle_hold: gnt=%b%b r_not_w=%b addr=%h, want 00 1 00000100",
                     if_gnt_o, d_gnt_o, mem_r_not_w_o, mem_addr_o);
        end
        wait_drain("b2b");
    endtask

    task automatic test_flush;
        if_req_i = 1'b1; if_addr_i = 32'h10;
        #1;
        total++;
        if (if_gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL flush_fetch_gnt: got %b want 1", if_gnt_o);
        end
        exp_if_cnt++;
        tick();
        if_req_i = 1'b0; flush_i = 1'b1; d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h30;
        #1;
        total++;
        if (d_gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL flush_load_gnt: got %b want 1", d_gnt_o);
        end
        push_d(32'h0030FFCF); exp_d_cnt++;
        tick();
        d_req_i = 1'b0; flush_i = 1'b0;
        wait_drain("flush_return");
        if_req_i = 1'b1; flush_i = 1'b1;
        #1;
        total++;
        if (if_gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL flush_grant_cycle_gnt: got %b want 1", if_gnt_o);
        end
        exp_if_cnt++;
        tick();
        if_req_i = 1'b0; flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (if_rvalid_o !== 1'b0) begin
                bad++;
                $display("FAIL flush_grant_cycle_drop_%0d: if_rvalid=%b want 0", i, if_rvalid_o);
            end
        end
    endtask

    task automatic test_stats;
`ifdef ARB_STATS_EN
        total++;
        if (if_gnt_cnt_o !== 16'(exp_if_cnt) || d_gnt_cnt_o !== 16'(exp_d_cnt)) begin
            bad++;
            $display("FAIL stats_counts: if=%0d d=%0d, want if=%0d d=%0d",
                     if_gnt_cnt_o, d_gnt_cnt_o, exp_if_cnt, exp_d_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_read;
        if_req_i = 1'b1; if_addr_i = 32'h10;
        #1;
        total++;
        if (if_gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_gnt: got %b want 1", if_gnt_o);
        end
        tick();
        if_req_i = 1'b0;
        reset_i = 1'b1;
        #1;
        total++;
        if (if_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0 || if_rdata_o !== 32'h0 ||
            d_rdata_o !== 32'h0 || mem_addr_o !== 32'h0 || mem_r_not_w_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_outputs: rv=%b%b if_rdata=%h d_rdata=%h addr=%h r_not_w=%b, want 00 0 0 0 1",
                     if_rvalid_o, d_rvalid_o, if_rdata_o, d_rdata_o, mem_addr_o, mem_r_not_w_o);
        end
`ifdef ARB_STATS_EN
        total++;
        if (if_gnt_cnt_o !== 16'd0 || d_gnt_cnt_o !== 16'd0) begin
            bad++;
            $display("FAIL rst_mid_stats: %h %h, want 0 0", if_gnt_cnt_o, d_gnt_cnt_o);
        end
`endif
        tick(); tick();
        reset_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (if_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid_no_return_%0d: rv=%b%b want 00", i, if_rvalid_o, d_rvalid_o);
            end
        end
    endtask

    initial begin
        mem_store[32'h10] = 32'hE3A01005;
        mem_rdata_i = 32'h0;
        test_reset();
        test_fetch();
        test_contention();
        test_store();
        test_back_to_back();
        test_flush();
        test_stats();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
